// File: rtl/des_pkg.sv
// ============================================================================
// Module  : des_pkg
// Brief   : Shared types for the DES block loader (state, block, index width).
//           Key byte storage depends on macro DES_LOADER_PARITY_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package des_pkg;

   localparam int c_IDX_W = 3;

   typedef logic [63:0]        block_t;
   typedef logic [c_IDX_W-1:0] idx_t;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      ISSUE   = 1'b1
   } state_t;

   // DES keys carry odd parity in bit 0 of every byte when the option is on.
   function automatic logic [7:0] key_byte(input logic [7:0] b);
`ifdef DES_LOADER_PARITY_EN
      return {b[7:1], ~^b[7:1]};
`else
      return b;
`endif
   endfunction

endpackage

`default_nettype wire

// File: rtl/des_block_loader_if.sv
// ============================================================================
// Module  : des_block_loader_if
// Brief   : Block offer/accept bus between the loader and a DES core.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface des_block_loader_if;
   import des_pkg::*;

   logic   des_valid;
   logic   des_ready;
   block_t des_key;
   block_t des_data;

   modport master (output des_valid, output des_key, output des_data, input des_ready);
   modport slave  (input des_valid, input des_key, input des_data, output des_ready);

endinterface

`default_nettype wire

// File: rtl/des_debounce.sv
// ============================================================================
// Module  : des_debounce
// Brief   : Two-flop synchroniser plus stability counter; one-cycle rise pulse.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module des_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int                 c_CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

   logic [1:0]         sync_q;
   logic               level_q, level_d;
   logic               rise_q, rise_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], raw};
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any sample equal to the current level restarts the stability count.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == c_CNT_LAST) begin
            level_d = sync_q[1];
            rise_d  = sync_q[1];
         end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
         end
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

`default_nettype wire

// File: rtl/des_block_loader.sv
// ============================================================================
// Module  : des_block_loader
// Brief   : Assembles a 64-bit DES key and plaintext from switch bytes and
//           offers them to a DES core. Optional macro: DES_LOADER_PARITY_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module des_block_loader
   import des_pkg::*;
#(
   parameter int DB_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          sw,
   input  logic                pb_byte,
   input  logic                pb_go,
   input  logic                sel_key,
   des_block_loader_if.master  des_bus,
   output logic [c_IDX_W-1:0]  byte_cnt,
   output logic [7:0]          led
);

   logic   w_byte_level, w_byte_rise, w_byte_pulse;
   logic   w_go_level, w_go_rise, w_go_pulse;

   state_t state_q, state_d;
   block_t key_q, key_d;
   block_t data_q, data_d;
   idx_t   key_idx_q, key_idx_d;
   idx_t   data_idx_q, data_idx_d;
   logic   key_full_q, key_full_d;
   logic   data_full_q, data_full_d;
   logic   go_err_q, go_err_d;

   des_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_byte (
      .clk   (clk),
      .rst   (rst),
      .raw   (pb_byte),
      .level (w_byte_level),
      .rise  (w_byte_rise)
   );

   des_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_go (
      .clk   (clk),
      .rst   (rst),
      .raw   (pb_go),
      .level (w_go_level),
      .rise  (w_go_rise)
   );

   assign w_byte_pulse = w_byte_rise & w_byte_level;
   assign w_go_pulse   = w_go_rise & w_go_level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= COLLECT;
         key_q       <= '0;
         data_q      <= '0;
         key_idx_q   <= '0;
         data_idx_q  <= '0;
         key_full_q  <= 1'b0;
         data_full_q <= 1'b0;
         go_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         data_q      <= data_d;
         key_idx_q   <= key_idx_d;
         data_idx_q  <= data_idx_d;
         key_full_q  <= key_full_d;
         data_full_q <= data_full_d;
         go_err_q    <= go_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      data_d      = data_q;
      key_idx_d   = key_idx_q;
      data_idx_d  = data_idx_q;
      key_full_d  = key_full_q;
      data_full_d = data_full_q;
      go_err_d    = go_err_q;
      case (state_q)
         COLLECT: begin
            // Go looks at the flags as they stood before any same-cycle capture.
            if (w_go_pulse) begin
               if (key_full_q && data_full_q) begin
                  state_d  = ISSUE;
                  go_err_d = 1'b0;
               end else begin
                  go_err_d = 1'b1;
               end
            end
            // Byte 0 lives in the top byte; the index wraps to 0 once full,
            // so the next capture both clears full and restarts at byte 0.
            if (w_byte_pulse) begin
               if (sel_key) begin
                  key_d[{~key_idx_q, 3'b000} +: 8] = key_byte(sw);
                  key_idx_d  = key_idx_q + 1'b1;
                  key_full_d = (key_idx_q == idx_t'(7));
               end else begin
                  data_d[{~data_idx_q, 3'b000} +: 8] = sw;
                  data_idx_d  = data_idx_q + 1'b1;
                  data_full_d = (data_idx_q == idx_t'(7));
               end
            end
         end
         ISSUE: begin
            if (des_bus.des_ready) begin
               state_d     = COLLECT;
               data_full_d = 1'b0;
               data_idx_d  = '0;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   assign des_bus.des_valid = (state_q == ISSUE);
   assign des_bus.des_key   = key_q;
   assign des_bus.des_data  = data_q;

   assign byte_cnt = sel_key ? key_idx_q : data_idx_q;
   assign led      = {go_err_q, 4'b0000, (state_q == ISSUE), data_full_q, key_full_q};

endmodule

`default_nettype wire

// File: tb/tb_des_block_loader.sv
// ============================================================================
// Module  : tb_des_block_loader
// Brief   : Self-checking bench: vector table for captures, scoreboard for
//           block transfers, hand sequences for go/reset corner cases.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_des_block_loader;
   import des_pkg::*;

   localparam int DB   = 4;
   localparam int HOLD = DB + 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sw = 8'h00;
   logic       pb_byte = 1'b0;
   logic       pb_go = 1'b0;
   logic       sel_key = 1'b0;
   logic [2:0] byte_cnt;
   logic [7:0] led;

   des_block_loader_if bus ();

   des_block_loader #(.DB_CYCLES(DB)) dut (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw),
      .pb_byte  (pb_byte),
      .pb_go    (pb_go),
      .sel_key  (sel_key),
      .des_bus  (bus),
      .byte_cnt (byte_cnt),
      .led      (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      block_t key;
      block_t data;
   } xfer_t;

   typedef struct {
      bit         sel;
      logic [7:0] sw;
      logic [2:0] cnt;
      logic [7:0] led;
   } vec_t;

   int     n_pass = 0;
   int     n_total = 0;
   int     v_cnt = 0;
   int     v0;
   xfer_t  sb[$];
   xfer_t  mon_e;
   vec_t   tv[16];

   block_t m_key = '0;
   block_t m_data = '0;
   int     mki = 0;
   int     mdi = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h", name, act, exp);
   endtask

   function automatic logic [7:0] kb(input logic [7:0] b);
`ifdef DES_LOADER_PARITY_EN
      return {b[7:1], ($countones(b[7:1]) % 2 == 0)};
`else
      return b;
`endif
   endfunction

   // Transfer monitor: the handshake seen at a falling edge completes at the next rise.
   always @(negedge clk) begin
      if (bus.des_valid === 1'b1) v_cnt++;
      if (bus.des_valid === 1'b1 && bus.des_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_xfer: actual key=%h data=%h required=no transfer",
                     bus.des_key, bus.des_data);
         end else begin
            mon_e = sb.pop_front();
            check("xfer_key", bus.des_key, mon_e.key);
            check("xfer_data", bus.des_data, mon_e.data);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_byte(input bit s, input logic [7:0] v);
      if (s) begin
         m_key[(7 - mki) * 8 +: 8] = kb(v);
         mki = (mki + 1) % 8;
      end else begin
         m_data[(7 - mdi) * 8 +: 8] = v;
         mdi = (mdi + 1) % 8;
      end
   endtask

   task automatic press_byte(input bit s, input logic [7:0] v, input bit upd);
      sel_key = s;
      sw      = v;
      pb_byte = 1'b1;
      tick(HOLD);
      pb_byte = 1'b0;
      tick(HOLD);
      if (upd) model_byte(s, v);
   endtask

   task automatic press_go();
      pb_go = 1'b1;
      tick(HOLD);
      pb_go = 1'b0;
      tick(HOLD);
   endtask

   task automatic go_expect_xfer();
      xfer_t e;
      e.key  = m_key;
      e.data = m_data;
      sb.push_back(e);
      mdi = 0;
      press_go();
   endtask

   task automatic apply_vec(input int i);
      press_byte(tv[i].sel, tv[i].sw, 1'b1);
      check($sformatf("vec%0d_byte_cnt", i), byte_cnt, tv[i].cnt);
      check($sformatf("vec%0d_led", i), led, tv[i].led);
   endtask

   initial begin
      tv[0]  = '{1'b1, 8'h13, 3'd1, 8'h00};
      tv[1]  = '{1'b1, 8'h34, 3'd2, 8'h00};
      tv[2]  = '{1'b1, 8'h57, 3'd3, 8'h00};
      tv[3]  = '{1'b1, 8'h79, 3'd4, 8'h00};
      tv[4]  = '{1'b1, 8'h9B, 3'd5, 8'h00};
      tv[5]  = '{1'b1, 8'hBC, 3'd6, 8'h00};
      tv[6]  = '{1'b1, 8'hDF, 3'd7, 8'h00};
      tv[7]  = '{1'b1, 8'hF1, 3'd0, 8'h01};
      tv[8]  = '{1'b0, 8'h01, 3'd1, 8'h01};
      tv[9]  = '{1'b0, 8'h23, 3'd2, 8'h01};
      tv[10] = '{1'b0, 8'h45, 3'd3, 8'h01};
      tv[11] = '{1'b0, 8'h67, 3'd4, 8'h01};
      tv[12] = '{1'b0, 8'h89, 3'd5, 8'h01};
      tv[13] = '{1'b0, 8'hAB, 3'd6, 8'h81};
      tv[14] = '{1'b0, 8'hCD, 3'd7, 8'h81};
      tv[15] = '{1'b0, 8'hEF, 3'd0, 8'h83};
      bus.des_ready = 1'b0;

      // Reset state
      tick(3);
      check("rst_valid", bus.des_valid, 0);
      check("rst_key", bus.des_key, 0);
      check("rst_data", bus.des_data, 0);
      check("rst_led", led, 0);
      check("rst_byte_cnt", byte_cnt, 0);
      rst = 1'b0;
      tick(2);

      // Glitch shorter than the debounce window
      sel_key = 1'b0;
      sw      = 8'hAA;
      pb_byte = 1'b1;
      tick(DB - 1);
      pb_byte = 1'b0;
      tick(HOLD);
      check("glitch_byte_cnt", byte_cnt, 0);
      check("glitch_data", bus.des_data, 0);

      // Full key and five plaintext bytes, then a premature go
      for (int i = 0; i < 13; i++) apply_vec(i);
      v0 = v_cnt;
      press_go();
      check("go_early_valid_cycles", v_cnt - v0, 0);
      check("go_early_led", led, 8'h81);

      for (int i = 13; i < 16; i++) apply_vec(i);

      // Good go with the core ready: exactly one valid cycle
      bus.des_ready = 1'b1;
      v0 = v_cnt;
      go_expect_xfer();
      check("go_ok_valid_cycles", v_cnt - v0, 1);
      check("go_ok_led", led, 8'h01);
      check("go_ok_key", bus.des_key, 64'h133457799BBCDFF1);
      check("go_ok_data", bus.des_data, 64'h0123456789ABCDEF);
      check("go_ok_byte_cnt", byte_cnt, 0);

      // Core stalls; button activity during ISSUE must be ignored
      bus.des_ready = 1'b0;
      for (int b = 0; b < 8; b++) press_byte(1'b0, 8'h10 + 8'(b), 1'b1);
      check("stall_pre_led", led, 8'h03);
      go_expect_xfer();
      check("stall_valid", bus.des_valid, 1);
      press_byte(1'b0, 8'hFF, 1'b0);
      press_go();
      check("stall_valid_held", bus.des_valid, 1);
      check("stall_key", bus.des_key, m_key);
      check("stall_data", bus.des_data, m_data);
      check("stall_led", led, 8'h07);
      v0 = v_cnt;
      bus.des_ready = 1'b1;
      tick(3);
      check("stall_xfer_cycles", v_cnt - v0, 1);
      check("stall_post_led", led, 8'h01);
      check("stall_post_byte_cnt", byte_cnt, 0);
      check("stall_post_data", bus.des_data, m_data);

      // Simultaneous byte and go: go judged on flags before the capture
      for (int b = 0; b < 7; b++) press_byte(1'b0, 8'hA0 + 8'(b), 1'b1);
      v0 = v_cnt;
      sel_key = 1'b0;
      sw      = 8'hA7;
      pb_byte = 1'b1;
      pb_go   = 1'b1;
      tick(HOLD);
      pb_byte = 1'b0;
      pb_go   = 1'b0;
      tick(HOLD);
      model_byte(1'b0, 8'hA7);
      check("simul_valid_cycles", v_cnt - v0, 0);
      check("simul_led", led, 8'h83);
      v0 = v_cnt;
      go_expect_xfer();
      check("simul_go_valid_cycles", v_cnt - v0, 1);
      check("simul_go_led", led, 8'h01);

      // Asynchronous reset while a block is offered
      bus.des_ready = 1'b0;
      for (int b = 0; b < 8; b++) press_byte(1'b0, 8'h50 + 8'(b), 1'b1);
      press_go();
      check("issue_valid", bus.des_valid, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", bus.des_valid, 0);
      check("arst_key", bus.des_key, 0);
      check("arst_led", led, 0);
      tick(2);
      rst = 1'b0;
      m_key = '0;
      m_data = '0;
      mki = 0;
      mdi = 0;
      tick(2);
      check("arst_data", bus.des_data, 0);
      check("arst_byte_cnt", byte_cnt, 0);
      v0 = v_cnt;
      press_go();
      check("arst_go_led", led, 8'h80);
      check("arst_go_valid_cycles", v_cnt - v0, 0);

      // Key byte storage (parity option shapes bit 0)
      bus.des_ready = 1'b1;
      press_byte(1'b1, 8'h00, 1'b1);
      check("kbyte00", bus.des_key[63:56], kb(8'h00));
      press_byte(1'b1, 8'h13, 1'b1);
      check("kbyte13", bus.des_key[55:48], kb(8'h13));
      check("kbyte_cnt", byte_cnt, 2);
      press_byte(1'b0, 8'h00, 1'b1);
      check("dbyte00", bus.des_data[63:56], 8'h00);
      check("parity_key_model", bus.des_key, m_key);

      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
